pc_fetch_ctrl: RTL and testbench

//  Drives the PC register's load side: produces the new-PC value and write strobe, and consumes the current PC.

---
 rtl/pc_fetch_ctrl_pkg.sv | 17 +
 rtl/pc_fetch_ctrl_instr_buf.sv | 63 ++++++
 rtl/pc_fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Purpose: shared widths and fetch-state encoding for the PC fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_fetch_ctrl_pkg;

  localparam int XLEN_DEF = 64;
  localparam int ILEN_DEF = 32;
  localparam int INC_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_UPD  = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_instr_buf.sv
// Purpose: one-entry instruction buffer between fetch and decode.
// Latency: load visible the cycle after the load strobe.
// Backpressure: holds its entry while valid && !ready; the caller never loads a full buffer.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   load, flush         capture in_instr/in_pc; drop the held entry
//   in_instr, in_pc     data to capture
//   ready               decode accepts this cycle
//   valid, instr, pc    buffered entry presented to decode
module pc_fetch_ctrl_instr_buf
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            ready,
  output logic            valid,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  logic            valid_q, valid_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    // A transfer and a flush in the same cycle both end with an empty buffer.
    if (valid_q && ready) valid_d = 1'b0;
    if (flush)            valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Purpose: PC load control, single-outstanding imem fetch and decode handoff with branch redirect.
// Latency: instruction and pc_w appear the cycle after imem_ack; 2-cycle minimum fetch period.
// Backpressure: stops requesting (HOLD) while the decode buffer is full and not ready.
//
// Ports:
//   clk, reset                        clock, async active-high reset
//   pc_cur / pc_new, pc_w             PC register read side / load value and one-cycle strobe
//   imem_req, imem_addr / imem_ack,   fetch request held until ack; rdata valid with ack
//   imem_rdata
//   redirect_valid, redirect_pc       taken branch/jump target (one-cycle pulse)
//   instr_valid, instr_ready,         decode valid/ready buffer output
//   instr, instr_pc
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_DEF,
  parameter int INC  = INC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_new,
  output logic            pc_w,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_new_q, pc_new_d;
  logic            pc_w_q, pc_w_d;
  logic            drop_q, drop_d;   // in-flight fetch belongs to a squashed path
  logic [XLEN-1:0] tgt_q, tgt_d;     // redirect target parked until the fetch completes
  logic            buf_load, buf_flush;
  logic [XLEN-1:0] pc_inc;

  // Wraps modulo 2^XLEN naturally.
  assign pc_inc    = pc_cur + XLEN'(INC);
  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = pc_cur;

  always_comb begin
    state_d   = state_q;
    pc_new_d  = pc_new_q;
    drop_d    = drop_q;
    tgt_d     = tgt_q;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect_valid) begin
          buf_flush = 1'b1;
          pc_new_d  = redirect_pc;
          state_d   = ST_UPD;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect_valid) begin
          buf_flush = 1'b1;
          if (imem_ack) begin
            pc_new_d = redirect_pc;
            drop_d   = 1'b0;
            state_d  = ST_UPD;
          end else begin
            // The handshake must still finish; remember where to go afterwards.
            tgt_d  = redirect_pc;
            drop_d = 1'b1;
          end
        end else if (imem_ack) begin
          state_d = ST_UPD;
          if (drop_q) begin
            pc_new_d = tgt_q;
            drop_d   = 1'b0;
          end else begin
            buf_load = 1'b1;
            pc_new_d = pc_inc;
          end
        end
      end
      ST_UPD: begin
        if (redirect_valid) begin
          // Re-entering UPD keeps pc_w high with the newer target.
          buf_flush = 1'b1;
          pc_new_d  = redirect_pc;
          state_d   = ST_UPD;
        end else if (instr_valid && !instr_ready) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          buf_flush = 1'b1;
          pc_new_d  = redirect_pc;
          state_d   = ST_UPD;
        end else if (instr_ready) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pc_w_d = (state_d == ST_UPD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_new_q <= '0;
      pc_w_q   <= 1'b0;
      drop_q   <= 1'b0;
      tgt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_new_q <= pc_new_d;
      pc_w_q   <= pc_w_d;
      drop_q   <= drop_d;
      tgt_q    <= tgt_d;
    end
  end

  assign pc_new = pc_new_q;
  assign pc_w   = pc_w_q;

  pc_fetch_ctrl_instr_buf #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_instr_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (buf_load),
    .flush    (buf_flush),
    .in_instr (imem_rdata),
    .in_pc    (pc_cur),
    .ready    (instr_ready),
    .valid    (instr_valid),
    .instr    (instr),
    .pc       (instr_pc)
  );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Purpose: scoreboard bench for pc_fetch_ctrl with a behavioural PC register and directed imem/redirect stimulus.
// Latency: n/a.
// Backpressure: decode readiness driven directly by the stimulus.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] pc_cur = '0;
  logic [63:0] pc_new;
  logic        pc_w;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  logic        pc_load = 1'b0;
  logic [63:0] pc_set = '0;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_pc_q[$];
  logic [95:0] exp_ins_q[$];

  pc_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .pc_cur         (pc_cur),
    .pc_new         (pc_new),
    .pc_w           (pc_w),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  // Behavioural PC register; the bench can also force a value into it.
  always @(posedge clk) begin
    if (pc_load)   pc_cur <= pc_set;
    else if (pc_w) pc_cur <= pc_new;
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    if (!imem_req) chk("imem_req_timeout", {95'b0, imem_req}, 96'd1);
  endtask

  task automatic fetch(input int lat, input logic [31:0] d);
    wait_req();
    repeat (lat) step();
    imem_ack   = 1'b1;
    imem_rdata = d;
    step();
    imem_ack   = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT strobes pc_w or hands an instruction to decode.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pc_w) begin
          if (exp_pc_q.size() == 0) chk("pc_w_spurious", {95'b0, pc_w}, 96'd0);
          else chk("pc_new", {32'b0, pc_new}, {32'b0, exp_pc_q.pop_front()});
        end
        if (instr_valid && instr_ready) begin
          if (exp_ins_q.size() == 0) chk("instr_spurious", {95'b0, instr_valid}, 96'd0);
          else chk("instr_and_pc", {instr, instr_pc}, exp_ins_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) step();
    chk("rst_pc_new", {32'b0, pc_new}, 96'd0);
    chk("rst_pc_w", {95'b0, pc_w}, 96'd0);
    chk("rst_imem_req", {95'b0, imem_req}, 96'd0);
    chk("rst_instr_valid", {95'b0, instr_valid}, 96'd0);
    chk("rst_instr", {64'b0, instr}, 96'd0);
    chk("rst_instr_pc", {32'b0, instr_pc}, 96'd0);
    reset = 1'b0;

    // 1: basic fetch at pc 0
    exp_ins_q.push_back({32'h0050_0093, 64'h0});
    exp_pc_q.push_back(64'h4);
    fetch(1, 32'h0050_0093);
    chk("t1_instr_valid", {95'b0, instr_valid}, 96'd1);
    step();

    // 2: decode stalls 5 cycles, fetch must stop
    instr_ready = 1'b0;
    exp_ins_q.push_back({32'h00A0_0113, 64'h4});
    exp_pc_q.push_back(64'h8);
    fetch(1, 32'h00A0_0113);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_req", {95'b0, imem_req}, 96'd0);
      step();
    end
    instr_ready = 1'b1;
    step();
    chk("t2_req_after_ready", {95'b0, imem_req}, 96'd1);
    chk("t2_buf_drained", {95'b0, instr_valid}, 96'd0);

    // 3: redirect while the fetch is in flight, 3-cycle ack
    wait_req();
    chk("t3_imem_addr", {32'b0, imem_addr}, 96'h8);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    exp_pc_q.push_back(64'h100);
    step();
    redirect_valid = 1'b0;
    chk("t3_still_req", {95'b0, imem_req}, 96'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("t3_no_instr", {95'b0, instr_valid}, 96'd0);
    step();

    // 4: redirect coinciding with ack, then another during UPD
    wait_req();
    chk("t4_imem_addr", {32'b0, imem_addr}, 96'h100);
    step();
    imem_ack       = 1'b1;
    imem_rdata     = 32'hBAD0_0001;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    exp_pc_q.push_back(64'h200);
    step();
    imem_ack    = 1'b0;
    redirect_pc = 64'h300;
    exp_pc_q.push_back(64'h300);
    chk("t4_pc_w_first", {95'b0, pc_w}, 96'd1);
    step();
    redirect_valid = 1'b0;
    chk("t4_pc_w_held", {95'b0, pc_w}, 96'd1);
    chk("t4_no_instr", {95'b0, instr_valid}, 96'd0);
    step();
    chk("t4_pc_w_drop", {95'b0, pc_w}, 96'd0);

    // 5: PC wrap
    pc_load = 1'b1;
    pc_set  = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    pc_load = 1'b0;
    exp_ins_q.push_back({32'h1234_5678, 64'hFFFF_FFFF_FFFF_FFFC});
    exp_pc_q.push_back(64'h0);
    fetch(0, 32'h1234_5678);
    step();

    // 6: reset in the middle of a request
    wait_req();
    step();
    reset = 1'b1;
    #1;
    chk("t6_req_async", {95'b0, imem_req}, 96'd0);
    chk("t6_pc_new", {32'b0, pc_new}, 96'd0);
    chk("t6_pc_w", {95'b0, pc_w}, 96'd0);
    chk("t6_instr_valid", {95'b0, instr_valid}, 96'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    step();
    imem_ack = 1'b0;
    chk("t6_ack_ignored_valid", {95'b0, instr_valid}, 96'd0);
    chk("t6_ack_ignored_instr", {64'b0, instr}, 96'd0);
    chk("t6_ack_ignored_pc_w", {95'b0, pc_w}, 96'd0);
    step();
    reset = 1'b0;

    // Recovery after reset
    exp_ins_q.push_back({32'h0010_0073, 64'h0});
    exp_pc_q.push_back(64'h4);
    fetch(1, 32'h0010_0073);
    repeat (5) step();
    chk("pc_queue_drained", {64'b0, 32'(exp_pc_q.size())}, 96'd0);
    chk("instr_queue_drained", {64'b0, 32'(exp_ins_q.size())}, 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
